// File: rtl/tt_um_window_sum_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_window_sum_decoder
// Brief    : Rebuilds 2-bit x/y/t samples from mod-4 moving-window sums
//            (inverse recurrence s[n] = S[n] - S[n-1] + s[n-W]).
//            Optional macro WSD_COUNT_EN exposes an accepted-sample counter
//            on uio_out.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_window_sum_decoder #(
    parameter int WINDOW_SIZE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int         NUM_CH   = 3;
    localparam logic [3:0] FILL_MAX = 4'(WINDOW_SIZE);

    logic       in_valid;
    logic       sync;

    logic [1:0] prev_q [NUM_CH];
    logic [1:0] prev_d [NUM_CH];
    logic [1:0] hist_q [NUM_CH][WINDOW_SIZE];
    logic [1:0] hist_d [NUM_CH][WINDOW_SIZE];
    logic [1:0] out_q  [NUM_CH];
    logic [1:0] out_d  [NUM_CH];
    logic [1:0] recon  [NUM_CH];
    logic       out_valid_q;
    logic       out_valid_d;
    logic [3:0] fill_q;
    logic [3:0] fill_d;
    logic       primed;

    assign in_valid = ui_in[6];
    assign sync     = ui_in[7];

    // Natural 2-bit wrap implements the mod-4 difference and sum directly.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            recon[c] = ui_in[2*c +: 2] - prev_q[c] + hist_q[c][0];
        end
    end

    always_comb begin
        prev_d      = prev_q;
        hist_d      = hist_q;
        out_d       = out_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        if (sync) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prev_d[c] = 2'd0;
                out_d[c]  = 2'd0;
                for (int i = 0; i < WINDOW_SIZE; i++) begin
                    hist_d[c][i] = 2'd0;
                end
            end
            fill_d = 4'd0;
        end else if (in_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prev_d[c] = ui_in[2*c +: 2];
                out_d[c]  = recon[c];
                for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
                    hist_d[c][i] = hist_q[c][i+1];
                end
                hist_d[c][WINDOW_SIZE-1] = recon[c];
            end
            if (fill_q < FILL_MAX) begin
                fill_d = fill_q + 4'd1;
            end
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prev_q[c] <= 2'd0;
                out_q[c]  <= 2'd0;
                for (int i = 0; i < WINDOW_SIZE; i++) begin
                    hist_q[c][i] <= 2'd0;
                end
            end
            fill_q      <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            hist_q      <= hist_d;
            out_q       <= out_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign primed = (fill_q == FILL_MAX);
    assign uo_out = {primed, out_valid_q, out_q[2], out_q[1], out_q[0]};

`ifdef WSD_COUNT_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sync) begin
            cnt_d = 8'd0;
        end else if (in_valid) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign uio_out = cnt_q;
    assign uio_oe  = 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

    wire unused_ok = &{1'b0, ena, uio_in};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_window_sum_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_window_sum_decoder
// Brief    : Directed self-checking bench for the window-sum decoder (W=4),
//            including an end-to-end run through a reference summer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_window_sum_decoder;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_window_sum_decoder #(.WINDOW_SIZE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step(input logic [7:0] ui);
        ui_in = ui;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        ui_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        step(8'h41);
        step(8'h43);
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset uo_out got=%h exp=%h", uo_out, 8'h00);
        end
        repeat (3) begin
            ui_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold uo_out got=%h exp=%h", uo_out, 8'h00);
        end
`ifdef WSD_COUNT_EN
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL reset_uio got=%h/%h exp=00/ff", uio_out, uio_oe);
        end
`else
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio got=%h/%h exp=00/00", uio_out, uio_oe);
        end
`endif
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h41);
        checks++;
        if (uo_out !== 8'h41) begin
            errors++;
            $display("FAIL reset_first_accept got=%h exp=%h", uo_out, 8'h41);
        end
    endtask

    task automatic test_basic_decode;
        logic [1:0] sums [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [1:0] exps [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step({2'b01, 4'b0000, sums[i]});
            exp = {(i >= 3), 1'b1, 4'b0000, exps[i]};
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("FAIL basic_decode[%0d] got=%h exp=%h", i, uo_out, exp);
            end
        end
        step(8'h00);
        checks++;
        if (uo_out !== 8'h81) begin
            errors++;
            $display("FAIL basic_idle got=%h exp=%h", uo_out, 8'h81);
        end
    endtask

    task automatic test_wrap;
        logic [1:0] sums [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step({2'b01, 2'b00, sums[i], 2'b00});
            exp = {(i == 3), 1'b1, 2'b00, 2'd3, 2'b00};
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("FAIL wrap_y[%0d] got=%h exp=%h", i, uo_out, exp);
            end
        end
    endtask

    task automatic test_gapped;
        logic [1:0] sums [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [1:0] exps [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step({2'b01, 4'b0000, sums[i]});
            exp = {(i >= 3), 1'b1, 4'b0000, exps[i]};
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("FAIL gapped_accept[%0d] got=%h exp=%h", i, uo_out, exp);
            end
            for (int g = 0; g < 3; g++) begin
                step({2'b00, 4'b0000, 2'(g)});
                exp = {(i >= 3), 1'b0, 4'b0000, exps[i]};
                checks++;
                if (uo_out !== exp) begin
                    errors++;
                    $display("FAIL gapped_idle[%0d.%0d] got=%h exp=%h", i, g, uo_out, exp);
                end
            end
        end
`ifdef WSD_COUNT_EN
        checks++;
        if (uio_out !== 8'd5) begin
            errors++;
            $display("FAIL gapped_cnt got=%0d exp=5", uio_out);
        end
`endif
    endtask

    task automatic test_sync_priority;
        logic [1:0] sums [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step({2'b01, 4'b0000, sums[i]});
        end
        step(8'hC2);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL sync_clear got=%h exp=%h", uo_out, 8'h00);
        end
`ifdef WSD_COUNT_EN
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL sync_cnt got=%h exp=00", uio_out);
        end
`endif
        step(8'h41);
        checks++;
        if (uo_out !== 8'h41) begin
            errors++;
            $display("FAIL sync_after got=%h exp=%h", uo_out, 8'h41);
        end
    endtask

    task automatic test_end_to_end;
        logic [1:0] win [3][4];
        logic [1:0] sum [3];
        logic [1:0] smp [3];
        logic [7:0] exp;
        int         bad = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            sum[c] = 2'd0;
            for (int k = 0; k < 4; k++) win[c][k] = 2'd0;
        end
        for (int n = 0; n < 1000; n++) begin
            // Reference summer: add newest sample, drop the one leaving the window.
            for (int c = 0; c < 3; c++) begin
                smp[c] = 2'($urandom_range(3, 0));
                sum[c] = sum[c] + smp[c] - win[c][0];
                for (int k = 0; k < 3; k++) win[c][k] = win[c][k+1];
                win[c][3] = smp[c];
            end
            step({2'b01, sum[2], sum[1], sum[0]});
            exp = {(n >= 3), 1'b1, smp[2], smp[1], smp[0]};
            checks++;
            if (uo_out !== exp) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL e2e[%0d] got=%h exp=%h", n, uo_out, exp);
            end
        end
`ifdef WSD_COUNT_EN
        checks++;
        if (uio_out !== 8'd232) begin
            errors++;
            $display("FAIL e2e_cnt got=%0d exp=232", uio_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_wrap();
        test_gapped();
        test_sync_priority();
        test_end_to_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_window_sum_decoder.md
# tt_um_window_sum_decoder

Receive-side counterpart of the team's 4-sample moving-window summer: accepts the packed 2-bit running sums (x, y, t), modulo 4, that the summer emits, and reconstructs the original 2-bit samples. Each reconstructed sample uses the inverse recurrence s[n] = S[n] − S[n−1] + s[n−W] (mod 4). The block is a Tiny Tapeout user tile with the standard tile pinout. It sits directly after the summer, or after any link carrying its sums, so that end-to-end encode/decode is checkable on silicon.

## Interface
- WINDOW_SIZE, 4: window depth W; must equal the summer's window; legal range 1..8.
- clk  in  1  tile clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ena  in  1  tile enable; ignored by logic.
- ui_in  in  8  [1:0] S_x, [3:2] S_y, [5:4] S_t (mod-4 sums); [6] in_valid; [7] sync (clear history).
- uo_out  out  8  [1:0] x, [3:2] y, [5:4] t (reconstructed samples); [6] out_valid; [7] primed.
- uio_in  in  8  unused.
- uio_out  out  8  accepted-sample counter (see Configuration).
- uio_oe  out  8  output enables for uio_out (see Configuration).

## Operation
- Per channel c ∈ {x, y, t}, the block holds:
  - prev_c: 2 bits, the last accepted sum.
  - hist_c[0..W−1]: 2 bits each, the last W reconstructed samples; hist_c[0] is the oldest.
- The block also holds:
  - fill: 4 bits, saturating at W.
  - cnt: 8 bits, wrapping.
  - Output register out_c for each channel, plus out_valid.
- Accept (in_valid=1, sync=0), for each channel:
  - s = (S_c − prev_c + hist_c[0]) mod 4, computed in 2 bits with natural wrap and no saturation.
  - out_c ← s; prev_c ← S_c.
  - hist shifts toward index 0; hist_c[W−1] ← s.
  - If fill < W, fill ← fill + 1. cnt ← cnt + 1, wrapping from 255 to 0.
- Idle (in_valid=0, sync=0):
  - History, prev, fill and cnt hold.
  - out_c holds its last value; out_valid ← 0.
- Sync (sync=1), regardless of in_valid:
  - prev, hist, fill, cnt and out_c all clear to 0; out_valid ← 0.
  - The sum presented in the same cycle is discarded.
  - sync takes priority over in_valid.
- primed = (fill == W), combinational from fill. Before primed, outputs are still exact, provided the summer also started from all-zero state.
- Reset: out_c=0, out_valid=0, primed=0, cnt=0, and all history/prev cleared.
- Reset asserted mid-stream aborts immediately; the first accept after release is treated as sample 1.
- There is no back-pressure: the block accepts every cycle that in_valid=1.

## Timing
- Latency is 1 cycle. A sum accepted at rising edge k appears on uo_out[5:0], with out_valid=1, from just after edge k until edge k+1.
- out_valid is high exactly one cycle per accepted sum; back-to-back accepts give out_valid continuously high.
- The feedback path hist_c[0] → s → hist_c[W−1] completes within one cycle. The decoder sustains full-rate input, one triple per clock.
- primed rises in the cycle after the W-th accept and stays high until sync or reset.
- uo_out bits are all registered or derived from registers; no combinational path from ui_in to uo_out.

## Configuration
- WSD_COUNT_EN defined:
  - uio_out = cnt, the number of accepted sums modulo 256.
  - uio_oe = 8'hFF.
- WSD_COUNT_EN undefined:
  - cnt is not built.
  - uio_out = 8'h00 and uio_oe = 8'h00.
- The macro has no effect on uo_out behaviour.

## Test plan
- Reset: hold rst_n=0 with random ui_in → uo_out=8'h00. With WSD_COUNT_EN, uio_out=8'h00 and uio_oe=8'hFF.
- Basic decode, W=4: S_x sequence 1,3,2,2,2 on consecutive valid cycles → x outputs 1,2,3,0,1. primed first reads 1 in the cycle after the 4th accept.
- Wrap arithmetic: S_y sequence 3,2,1,0 with S_x=S_t=0 → y outputs 3,3,3,3. Each step's S_y − prev_y is −1, which must wrap to 3.
- Gapped input: insert 3 idle cycles between the accepts of the basic-decode sequence → same x outputs, out_valid pulses once per accept, and uo_out[5:0] holds during gaps.
- Sync priority: after 5 accepts, assert sync=1 together with in_valid=1 and S_x=2 → the next cycle shows uo_out=8'h00 and cnt=0. The following accept of S_x=1 yields x=1.
- End-to-end: feed a random 1000-sample (x, y, t) stream through a reference summer model, W=4, into the block → every reconstructed sample matches the original. With WSD_COUNT_EN, uio_out = 1000 mod 256 = 232 at the end.
